// File: rtl/cam_align_pkg.sv
// Shared types and default constants for the camera LVDS word aligner.
package cam_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } lane_state_e;

  localparam logic [7:0] DEF_TRAIN_WORD = 8'hE5;
  localparam int         DEF_SETTLE     = 4;
  localparam int         DEF_MATCH_N    = 16;

  // A lane counts as busy while it is still hunting for alignment.
  function automatic logic lane_is_busy(input lane_state_e s);
    return (s == ST_CHECK) || (s == ST_SLIP) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/cam_bitslip_lane.sv
// One lane of the word aligner: compares the polarity-corrected word against the
// training word, issues single-cycle bitslip pulses, and reports lock or failure.
module cam_bitslip_lane
  import cam_align_pkg::*;
#(
  parameter int               DESER      = 8,
  parameter logic [DESER-1:0] TRAIN_WORD = DESER'(DEF_TRAIN_WORD),
  parameter int               SETTLE     = DEF_SETTLE,
  parameter int               MATCH_N    = DEF_MATCH_N,
  localparam int              CW         = $clog2(DESER + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DESER-1:0] word_i,
  output logic             bitslip_o,
  output logic             locked_o,
  output logic             fail_o,
  output logic             busy_o,
  output logic [CW-1:0]    slipCnt_o
);

  localparam int MW = $clog2(MATCH_N + 1);
  localparam int SW = $clog2(SETTLE + 1);

  lane_state_e   state_q;
  logic [MW-1:0] matchCnt_q;
  logic [CW-1:0] slipCnt_q;
  logic [SW-1:0] settleCnt_q;
  logic          bitslip_q;
  logic          locked_q;
  logic          fail_q;

  // Lane FSM; the bitslip pulse is raised on entry to SLIP so it is high for exactly that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      matchCnt_q  <= '0;
      slipCnt_q   <= '0;
      settleCnt_q <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else if (start_i) begin
      state_q     <= ST_CHECK;
      matchCnt_q  <= '0;
      slipCnt_q   <= '0;
      settleCnt_q <= '0;
      bitslip_q   <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (word_i == TRAIN_WORD) begin
            if (matchCnt_q == MW'(MATCH_N - 1)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              matchCnt_q <= matchCnt_q + 1'b1;
            end
          end else begin
            matchCnt_q <= '0;
            if (slipCnt_q == CW'(DESER)) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q   <= ST_SLIP;
              bitslip_q <= 1'b1;
            end
          end
        end
        ST_SLIP: begin
          bitslip_q   <= 1'b0;
          settleCnt_q <= '0;
          state_q     <= ST_WAIT;
          if (slipCnt_q != CW'(DESER)) begin
            slipCnt_q <= slipCnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (settleCnt_q == SW'(SETTLE - 1)) begin
            state_q <= ST_CHECK;
          end else begin
            settleCnt_q <= settleCnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign fail_o    = fail_q;
  assign slipCnt_o = slipCnt_q;
  assign busy_o    = lane_is_busy(state_q);

endmodule

// File: rtl/cam_bitslip_align.sv
// Per-camera word aligner: polarity-corrects every deserialiser lane, runs one
// alignment FSM per lane, and registers the corrected data and summary flags.
module cam_bitslip_align
  import cam_align_pkg::*;
#(
  parameter int                 N_LANES    = 5,
  parameter int                 DESER      = 8,
  parameter logic [DESER-1:0]   TRAIN_WORD = DESER'(DEF_TRAIN_WORD),
  parameter logic [N_LANES-1:0] INVERT     = N_LANES'('h0F),
  parameter int                 SETTLE     = DEF_SETTLE,
  parameter int                 MATCH_N    = DEF_MATCH_N,
  localparam int                CW         = $clog2(DESER + 1)
) (
  input  logic                     c,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_LANES*DESER-1:0] rxd_in,
  output logic [N_LANES-1:0]       bitslip,
  output logic [N_LANES*DESER-1:0] rxd_out,
  output logic [N_LANES-1:0]       lane_locked,
  output logic [N_LANES-1:0]       lane_fail,
  output logic [N_LANES*CW-1:0]    slip_cnt,
  output logic                     all_locked,
  output logic                     busy
);

  logic [N_LANES*DESER-1:0] rxdCorr;
  logic [N_LANES-1:0]       laneBusy;
  logic [N_LANES*DESER-1:0] rxdOut_q;
  logic                     allLocked_q;
  logic                     busy_q;
  logic                     allLocked_d;
  logic                     busy_d;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign rxdCorr[g*DESER +: DESER] = rxd_in[g*DESER +: DESER] ^ {DESER{INVERT[g]}};

    cam_bitslip_lane #(
      .DESER      (DESER),
      .TRAIN_WORD (TRAIN_WORD),
      .SETTLE     (SETTLE),
      .MATCH_N    (MATCH_N)
    ) u_lane (
      .clk_i     (c),
      .rst_ni    (rst_n),
      .start_i   (start),
      .word_i    (rxdCorr[g*DESER +: DESER]),
      .bitslip_o (bitslip[g]),
      .locked_o  (lane_locked[g]),
      .fail_o    (lane_fail[g]),
      .busy_o    (laneBusy[g]),
      .slipCnt_o (slip_cnt[g*CW +: CW])
    );
  end

  assign allLocked_d = &lane_locked;
  assign busy_d      = |laneBusy;

  // Corrected data and summary flags, registered one cycle behind the lanes.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      rxdOut_q    <= '0;
      allLocked_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rxdOut_q    <= rxdCorr;
      allLocked_q <= allLocked_d;
      busy_q      <= busy_d;
    end
  end

  assign rxd_out    = rxdOut_q;
  assign all_locked = allLocked_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cam_bitslip_align.sv
// Bench for the camera word aligner: emulates five deserialiser lanes that rotate
// one bit per bitslip pulse and predicts each lane's outcome from the rotation rules.
module tb_cam_bitslip_align;

  localparam int NL = 5;
  localparam int DW = 8;
  localparam int CWT = 4;
  localparam int GAP_MIN = 6;

  typedef struct packed {
    logic [NL-1:0]     locked;
    logic [NL*CWT-1:0] slips;
  } outcome_t;

  logic                c = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [NL*DW-1:0]    rxd_in = '0;
  logic [NL-1:0]       bitslip;
  logic [NL*DW-1:0]    rxd_out;
  logic [NL-1:0]       lane_locked;
  logic [NL-1:0]       lane_fail;
  logic [NL*CWT-1:0]   slip_cnt;
  logic                all_locked;
  logic                busy;

  logic [NL-1:0] invMask = 5'h0F;
  logic [7:0]    pattern [NL];
  int            rot [NL];
  int            baseRot [NL];
  int            pulseCnt [NL];
  int            lastPulse [NL];
  int            minGap [NL];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  cam_bitslip_align #(
    .N_LANES    (NL),
    .DESER      (DW),
    .TRAIN_WORD (8'hE5),
    .INVERT     (5'h0F),
    .SETTLE     (4),
    .MATCH_N    (16)
  ) dut (
    .c           (c),
    .rst_n       (rst_n),
    .start       (start),
    .rxd_in      (rxd_in),
    .bitslip     (bitslip),
    .rxd_out     (rxd_out),
    .lane_locked (lane_locked),
    .lane_fail   (lane_fail),
    .slip_cnt    (slip_cnt),
    .all_locked  (all_locked),
    .busy        (busy)
  );

  always #5 c = ~c;

  always @(posedge c) cyc++;

  function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
    logic [15:0] t;
    t = {w, w} << (r % 8);
    return t[15:8];
  endfunction

  // Raw deserialiser output: the lane's word at its current rotation, then board inversion.
  function automatic void drive_rx();
    for (int i = 0; i < NL; i++) begin
      rxd_in[i*DW +: DW] = rotl(pattern[i], rot[i]) ^ (invMask[i] ? 8'hFF : 8'h00);
    end
  endfunction

  // Lane model reaction to bitslip, plus pulse counting and spacing tracking.
  always @(negedge c) begin
    for (int i = 0; i < NL; i++) begin
      if (bitslip[i]) begin
        rot[i] = (rot[i] + 1) % 8;
        pulseCnt[i]++;
        if (lastPulse[i] >= 0 && (cyc - lastPulse[i]) < minGap[i]) minGap[i] = cyc - lastPulse[i];
        lastPulse[i] = cyc;
      end
    end
    drive_rx();
  end

  function automatic void clear_mon();
    for (int i = 0; i < NL; i++) begin
      pulseCnt[i] = 0;
      lastPulse[i] = -1;
      minGap[i] = 1000;
      baseRot[i] = rot[i];
    end
  endfunction

  function automatic void set_lane(input int i, input logic [7:0] p, input int k);
    pattern[i] = p;
    rot[i] = k;
  endfunction

  // Outcome from the rules: the lane locks after the fewest slips that bring its word to
  // 8'hE5; if no rotation ever matches it fails after DESER slips.
  function automatic outcome_t predict();
    outcome_t o;
    o = '0;
    for (int i = 0; i < NL; i++) begin
      int s;
      s = 8;
      for (int t = 7; t >= 0; t--) begin
        if (rotl(pattern[i], baseRot[i] + t) == 8'hE5) s = t;
      end
      o.locked[i] = (s < 8);
      o.slips[i*CWT +: CWT] = CWT'(s);
    end
    return o;
  endfunction

  function automatic logic [NL*CWT-1:0] packed_pulses();
    logic [NL*CWT-1:0] v;
    for (int i = 0; i < NL; i++) v[i*CWT +: CWT] = CWT'(pulseCnt[i]);
    return v;
  endfunction

  function automatic int worst_gap();
    int w;
    w = 1000;
    for (int i = 0; i < NL; i++) if (minGap[i] < w) w = minGap[i];
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge c);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (((lane_locked | lane_fail) !== 5'h1F) && n < budget) begin
      @(negedge c);
      n++;
    end
    checks++;
    if ((lane_locked | lane_fail) !== 5'h1F) begin
      errors++;
      $display("[TB] FAIL %s_done: locked|fail=%h required 1f within %0d cycles", tag, lane_locked | lane_fail, budget);
    end
    @(negedge c);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NL; i++) set_lane(i, 8'($urandom), $urandom_range(0, 7));
    drive_rx();
    clear_mon();
    repeat (3) @(negedge c);
    checks++; if (bitslip !== '0) begin errors++; $display("[TB] FAIL reset_bitslip: got %h required 0", bitslip); end
    checks++; if (rxd_out !== '0) begin errors++; $display("[TB] FAIL reset_rxd_out: got %h required 0", rxd_out); end
    checks++; if (lane_locked !== '0) begin errors++; $display("[TB] FAIL reset_locked: got %h required 0", lane_locked); end
    checks++; if (lane_fail !== '0) begin errors++; $display("[TB] FAIL reset_fail: got %h required 0", lane_fail); end
    checks++; if (slip_cnt !== '0) begin errors++; $display("[TB] FAIL reset_slip_cnt: got %h required 0", slip_cnt); end
    checks++; if ({all_locked, busy} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: all_locked/busy=%b required 00", {all_locked, busy}); end
    rst_n = 1'b1;
    repeat (100) @(negedge c);
    checks++; if (packed_pulses() !== '0) begin errors++; $display("[TB] FAIL idle_no_pulse: pulses=%h required 0", packed_pulses()); end
    checks++; if ({busy, lane_locked} !== '0) begin errors++; $display("[TB] FAIL idle_state: busy/locked=%h required 0", {busy, lane_locked}); end
  endtask

  task automatic test_prealigned();
    for (int i = 0; i < NL; i++) set_lane(i, 8'hE5, 0);
    drive_rx();
    clear_mon();
    pulse_start();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_delay: got %b required 0 right after start edge", busy); end
    @(negedge c);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise: got %b required 1", busy); end
    repeat (14) @(negedge c);
    checks++; if (lane_locked !== 5'h00) begin errors++; $display("[TB] FAIL early_lock: got %h required 00 at 15 cycles", lane_locked); end
    @(negedge c);
    checks++; if (lane_locked !== 5'h1F) begin errors++; $display("[TB] FAIL lock_16: got %h required 1f at 16 cycles", lane_locked); end
    checks++; if (all_locked !== 1'b0) begin errors++; $display("[TB] FAIL all_locked_delay: got %b required 0", all_locked); end
    @(negedge c);
    checks++; if (all_locked !== 1'b1) begin errors++; $display("[TB] FAIL all_locked: got %b required 1", all_locked); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_fall: got %b required 0", busy); end
    checks++; if (slip_cnt !== '0) begin errors++; $display("[TB] FAIL pre_slip_cnt: got %h required 0", slip_cnt); end
    checks++; if (packed_pulses() !== '0) begin errors++; $display("[TB] FAIL pre_pulses: got %h required 0", packed_pulses()); end
  endtask

  task automatic test_rotated();
    int kTab [NL];
    outcome_t exp;
    kTab = '{0, 1, 3, 5, 7};
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < NL; i++) begin
        if (round == 0) set_lane(i, 8'hE5, kTab[i]);
        else if (round == 1) set_lane(i, 8'hE5, $urandom_range(0, 7));
        else set_lane(i, ($urandom_range(0, 1) == 1) ? 8'hE5 : 8'($urandom), $urandom_range(0, 7));
      end
      drive_rx();
      clear_mon();
      exp = predict();
      pulse_start();
      wait_done("rotated", 200);
      checks++; if (lane_locked !== exp.locked) begin errors++; $display("[TB] FAIL rot%0d_locked: got %h required %h", round, lane_locked, exp.locked); end
      checks++; if (lane_fail !== ~exp.locked) begin errors++; $display("[TB] FAIL rot%0d_fail: got %h required %h", round, lane_fail, ~exp.locked); end
      checks++; if (slip_cnt !== exp.slips) begin errors++; $display("[TB] FAIL rot%0d_slip_cnt: got %h required %h", round, slip_cnt, exp.slips); end
      checks++; if (packed_pulses() !== exp.slips) begin errors++; $display("[TB] FAIL rot%0d_pulses: got %h required %h", round, packed_pulses(), exp.slips); end
      checks++; if (worst_gap() < GAP_MIN) begin errors++; $display("[TB] FAIL rot%0d_gap: got %0d required >=%0d", round, worst_gap(), GAP_MIN); end
      checks++; if (all_locked !== (&exp.locked)) begin errors++; $display("[TB] FAIL rot%0d_all_locked: got %b required %b", round, all_locked, &exp.locked); end
    end
  endtask

  task automatic test_inversion();
    logic [NL*DW-1:0] expOut;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NL; i++) set_lane(i, 8'($urandom), 0);
      drive_rx();
      expOut = '0;
      for (int i = 0; i < NL; i++) expOut[i*DW +: DW] = pattern[i];
      checks++; if (rxd_out === expOut) begin errors++; $display("[TB] FAIL rxd_out_early: got %h before the clock edge", rxd_out); end
      @(negedge c);
      checks++; if (rxd_out !== expOut) begin errors++; $display("[TB] FAIL rxd_out_%0d: got %h required %h", n, rxd_out, expOut); end
    end
    for (int i = 0; i < NL; i++) set_lane(i, 8'hE5, 0);
    set_lane(1, 8'hE5, 2);
    drive_rx();
    clear_mon();
    @(negedge c);
    checks++; if (rxd_out[15:8] !== rotl(8'hE5, 2)) begin errors++; $display("[TB] FAIL inv_rxd_out: got %h required %h", rxd_out[15:8], rotl(8'hE5, 2)); end
    pulse_start();
    wait_done("inversion", 200);
    checks++; if (lane_locked[1] !== 1'b1) begin errors++; $display("[TB] FAIL inv_lock: got %b required 1", lane_locked[1]); end
    checks++; if (slip_cnt[7:4] !== 4'd6) begin errors++; $display("[TB] FAIL inv_slip_cnt: got %0d required 6", slip_cnt[7:4]); end
    checks++; if (rxd_out[15:8] !== 8'hE5) begin errors++; $display("[TB] FAIL inv_word: got %h required e5", rxd_out[15:8]); end
  endtask

  task automatic test_fail();
    outcome_t exp;
    for (int i = 0; i < NL - 1; i++) set_lane(i, 8'hE5, $urandom_range(0, 7));
    set_lane(4, 8'h00, 0);
    drive_rx();
    clear_mon();
    exp = predict();
    pulse_start();
    wait_done("fail", 200);
    checks++; if (pulseCnt[4] != 8) begin errors++; $display("[TB] FAIL fail_pulses: got %0d required 8", pulseCnt[4]); end
    checks++; if (lane_fail !== 5'h10) begin errors++; $display("[TB] FAIL fail_vec: got %h required 10", lane_fail); end
    checks++; if (lane_locked !== 5'h0F) begin errors++; $display("[TB] FAIL fail_locked: got %h required 0f", lane_locked); end
    checks++; if (all_locked !== 1'b0) begin errors++; $display("[TB] FAIL fail_all_locked: got %b required 0", all_locked); end
    checks++; if (slip_cnt !== exp.slips) begin errors++; $display("[TB] FAIL fail_slip_cnt: got %h required %h", slip_cnt, exp.slips); end
    checks++; if (worst_gap() < GAP_MIN) begin errors++; $display("[TB] FAIL fail_gap: got %0d required >=%0d", worst_gap(), GAP_MIN); end
  endtask

  task automatic test_restart();
    outcome_t exp;
    set_lane(0, 8'hE5, 0);
    for (int i = 1; i < NL - 1; i++) set_lane(i, 8'hE5, 3);
    set_lane(4, 8'h00, 0);
    drive_rx();
    clear_mon();
    pulse_start();
    repeat (20) @(negedge c);
    checks++; if (lane_locked !== 5'h01) begin errors++; $display("[TB] FAIL pre_restart_locked: got %h required 01", lane_locked); end
    pulse_start();
    checks++; if ({lane_locked, lane_fail} !== '0) begin errors++; $display("[TB] FAIL restart_clear: locked/fail=%h required 0", {lane_locked, lane_fail}); end
    checks++; if (slip_cnt !== '0) begin errors++; $display("[TB] FAIL restart_slip_cnt: got %h required 0", slip_cnt); end
    clear_mon();
    exp = predict();
    wait_done("restart", 200);
    checks++; if (lane_locked !== exp.locked) begin errors++; $display("[TB] FAIL restart_locked: got %h required %h", lane_locked, exp.locked); end
    checks++; if (slip_cnt !== exp.slips) begin errors++; $display("[TB] FAIL restart_slips: got %h required %h", slip_cnt, exp.slips); end
    checks++; if (packed_pulses() !== exp.slips) begin errors++; $display("[TB] FAIL restart_pulses: got %h required %h", packed_pulses(), exp.slips); end
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < NL; i++) set_lane(i, 8'hE5, 1);
    drive_rx();
    clear_mon();
    pulse_start();
    n = 0;
    while (bitslip === '0 && n < 20) begin
      @(negedge c);
      n++;
    end
    checks++; if (bitslip !== 5'h1F) begin errors++; $display("[TB] FAIL mid_slip_pulse: got %h required 1f", bitslip); end
    rst_n = 1'b0;
    #1;
    checks++; if (bitslip !== '0) begin errors++; $display("[TB] FAIL async_bitslip: got %h required 0", bitslip); end
    checks++; if ({lane_locked, lane_fail, slip_cnt} !== '0) begin errors++; $display("[TB] FAIL async_state: got %h required 0", {lane_locked, lane_fail, slip_cnt}); end
    @(negedge c);
    rst_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge c);
    checks++; if (packed_pulses() !== '0) begin errors++; $display("[TB] FAIL post_reset_pulses: got %h required 0", packed_pulses()); end
  endtask

  initial begin
    for (int i = 0; i < NL; i++) set_lane(i, 8'h00, 0);
    clear_mon();
    @(negedge c);
    test_reset();
    test_prealigned();
    test_rotated();
    test_inversion();
    test_fail();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
